seq_mul_div_ctrl: RTL and testbench

SEQ_MUL_DIV_CTRL -- requirements
Module: seq_mul_div_ctrl

---
 rtl/seq_mul_div_ctrl_pkg.sv | 15 +
 rtl/seq_mul_div_ctrl_addsub_row.sv | 36 +++
 rtl/seq_mul_div_ctrl.sv | 116 +++++++++++
 tb/tb_seq_mul_div_ctrl.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/seq_mul_div_ctrl_pkg.sv
// Shared encodings and defaults for the sequential multiply/divide controller.
package seq_mul_div_ctrl_pkg;

  localparam int WIDTH_DEF = 4;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/seq_mul_div_ctrl_addsub_row.sv
// Ripple add/subtract row built from full-adder cells; SUB inverts b and injects carry-in.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module addsub_row #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] b_eff;

  assign c[0]  = sub;
  assign b_eff = b ^ {WIDTH{sub}};
  assign cout  = c[WIDTH];

  fa_cell u_fa [WIDTH-1:0] (
    .a  (a),
    .b  (b_eff),
    .ci (c[WIDTH-1:0]),
    .s  (sum),
    .co (c[WIDTH:1])
  );
endmodule

// File: rtl/seq_mul_div_ctrl.sv
// Sequential shift-add multiplier / restoring divider sharing one add/sub row.
module seq_mul_div_ctrl
  import seq_mul_div_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             OP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT_HI,
  output logic [WIDTH-1:0] RESULT_LO,
  output logic             DIV_BY_ZERO
);
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic             op_q;
  logic             dbz_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;

  logic [WIDTH-1:0] rem_sh;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] sum;
  logic             cout;

  // Divide: acc_hi is the remainder, acc_lo the dividend shifting into the quotient.
  // The remainder never exceeds the consumed dividend prefix, so this shift cannot overflow.
  assign rem_sh = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
  assign add_a  = (op_q == OP_DIV) ? rem_sh : acc_hi;

  addsub_row #(.WIDTH(WIDTH)) u_row (
    .a    (add_a),
    .b    (opnd),
    .sub  (op_q),
    .sum  (sum),
    .cout (cout)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state       <= IDLE;
      cnt         <= '0;
      op_q        <= OP_MUL;
      dbz_q       <= 1'b0;
      opnd        <= '0;
      acc_hi      <= '0;
      acc_lo      <= '0;
      BUSY        <= 1'b0;
      DONE        <= 1'b0;
      RESULT_HI   <= '0;
      RESULT_LO   <= '0;
      DIV_BY_ZERO <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          // DONE high means we just left FINISH; a START in that cycle is dropped.
          if (START && !DONE) begin
            op_q <= OP;
            BUSY <= 1'b1;
            cnt  <= CW'(WIDTH);
            opnd <= (OP == OP_DIV) ? B : A;
            if (OP == OP_DIV && B == '0) begin
              acc_hi <= A;
              acc_lo <= '1;
              dbz_q  <= 1'b1;
              state  <= FINISH;
            end else begin
              acc_hi <= '0;
              acc_lo <= (OP == OP_DIV) ? A : B;
              dbz_q  <= 1'b0;
              state  <= CALC;
            end
          end
        end
        CALC: begin
          cnt <= cnt - 1'b1;
          if (op_q == OP_MUL) begin
            if (acc_lo[0])
              {acc_hi, acc_lo} <= {cout, sum, acc_lo[WIDTH-1:1]};
            else
              {acc_hi, acc_lo} <= {1'b0, acc_hi, acc_lo[WIDTH-1:1]};
          end else begin
            if (cout) begin
              acc_hi <= sum;
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
              acc_hi <= rem_sh;
              acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
          end
          if (cnt == CW'(1))
            state <= FINISH;
        end
        FINISH: begin
          DONE        <= 1'b1;
          BUSY        <= 1'b0;
          RESULT_HI   <= acc_hi;
          RESULT_LO   <= acc_lo;
          DIV_BY_ZERO <= dbz_q;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mul_div_ctrl.sv
// Scoreboard bench: stimulus queues expected results, a negedge monitor checks each DONE.
module tb_seq_mul_div_ctrl;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       OP = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       BUSY, DONE, DIV_BY_ZERO;
  logic [3:0] RESULT_HI, RESULT_LO;

  seq_mul_div_ctrl #(.WIDTH(4)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .START       (START),
    .OP          (OP),
    .A           (A),
    .B           (B),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .RESULT_HI   (RESULT_HI),
    .RESULT_LO   (RESULT_LO),
    .DIV_BY_ZERO (DIV_BY_ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] hi;
    logic [3:0] lo;
    logic       dbz;
    int         at;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every DONE must match the oldest queued expectation.
  always @(negedge CLK) begin
    if (!RST && DONE) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("result_hi", RESULT_HI, e.hi);
        chk("result_lo", RESULT_LO, e.lo);
        chk("div_by_zero", DIV_BY_ZERO, e.dbz);
        chk("done_cycle", cyc, e.at);
        chk("busy_at_done", BUSY, 1'b0);
      end
    end
  end

  // Called on a negedge; returns one negedge later with START dropped.
  task automatic start_op(input logic op, input logic [3:0] a, input logic [3:0] b,
                          input bit push, input logic [3:0] hi, input logic [3:0] lo,
                          input logic dbz, input int lat);
    exp_t e;
    START = 1'b1; OP = op; A = a; B = b;
    if (push) begin
      e.hi = hi; e.lo = lo; e.dbz = dbz; e.at = cyc + 1 + lat;
      q.push_back(e);
    end
    @(negedge CLK);
    START = 1'b0;
    chk("busy_after_start", BUSY, 1'b1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge CLK);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout pending %0d expected 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_hi", RESULT_HI, 4'h0);
    chk("rst_lo", RESULT_LO, 4'h0);
    chk("rst_dbz", DIV_BY_ZERO, 1'b0);
    RST = 1'b0;

    // Directed vectors
    start_op(1'b0, 4'd3, 4'd5, 1, 4'h0, 4'hF, 1'b0, 5);
    wait_idle();
    start_op(1'b0, 4'd15, 4'd15, 1, 4'hE, 4'h1, 1'b0, 5);
    wait_idle();
    start_op(1'b1, 4'd13, 4'd4, 1, 4'h1, 4'h3, 1'b0, 5);
    wait_idle();
    start_op(1'b1, 4'd15, 4'd15, 1, 4'h0, 4'h1, 1'b0, 5);
    wait_idle();
    start_op(1'b1, 4'd7, 4'd0, 1, 4'h7, 4'hF, 1'b1, 1);
    wait_idle();
    repeat (3) @(negedge CLK);
    chk("hold_hi", RESULT_HI, 4'h7);
    chk("hold_lo", RESULT_LO, 4'hF);
    chk("hold_dbz", DIV_BY_ZERO, 1'b1);

    // Second START during CALC is ignored
    start_op(1'b0, 4'd2, 4'd3, 1, 4'h0, 4'h6, 1'b0, 5);
    @(negedge CLK);
    START = 1'b1; OP = 1'b0; A = 4'd9; B = 4'd9;
    @(negedge CLK);
    START = 1'b0;
    wait_idle();
    repeat (8) @(negedge CLK);
    chk("no_restart_busy", BUSY, 1'b0);

    // START in the DONE cycle is ignored
    start_op(1'b0, 4'd3, 4'd5, 1, 4'h0, 4'hF, 1'b0, 5);
    begin
      int n;
      n = 0;
      while (!DONE && n < 20) begin
        @(negedge CLK);
        n++;
      end
      chk("done_seen", DONE, 1'b1);
    end
    START = 1'b1; OP = 1'b0; A = 4'd1; B = 4'd1;
    @(negedge CLK);
    START = 1'b0;
    repeat (8) @(negedge CLK);
    chk("done_cycle_start_busy", BUSY, 1'b0);
    chk("done_cycle_start_lo", RESULT_LO, 4'hF);

    // Reset mid-operation aborts it
    start_op(1'b0, 4'd9, 4'd9, 0, 4'h0, 4'h0, 1'b0, 0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    chk("abort_busy", BUSY, 1'b0);
    chk("abort_done", DONE, 1'b0);
    chk("abort_hi", RESULT_HI, 4'h0);
    chk("abort_lo", RESULT_LO, 4'h0);
    chk("abort_dbz", DIV_BY_ZERO, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    start_op(1'b1, 4'd9, 4'd2, 1, 4'h1, 4'h4, 1'b0, 5);
    wait_idle();
    repeat (10) @(negedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
